// File: rtl/accumulator_alu.sv
// accumulator_alu: accumulator ALU with Z/C/N flags, single-cycle logic/add/shift ops and an 8-cycle 8x8 shift-add multiply
module accumulator_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_out,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n,
  output logic             done,
  output logic             busy
);
  typedef enum logic {IDLE, MUL} state_t;
  state_t           state;
  logic [7:0]       mcand, mplier;
  logic [2:0]       cnt;
  logic [WIDTH-1:0] product, prod_next, res;
  logic [WIDTH:0]   sum;
  logic             carry;
  assign op_ready = (state == IDLE) && !rst;
  assign busy     = (state == MUL);
  always_comb begin
    sum       = {1'b0, acc_out} + {1'b0, operand};
    res       = '0;
    carry     = 1'b0;
    prod_next = product + (mplier[cnt] ? ({{(WIDTH-8){1'b0}}, mcand} << cnt) : '0);
    case (op_code)
      3'b000:  res = operand;
      3'b001:  {carry, res} = sum;
      3'b010:  res = acc_out & operand;
      3'b011:  res = acc_out | operand;
      3'b100:  res = acc_out ^ operand;
      3'b101:  {carry, res} = {acc_out, 1'b0};
      3'b110:  {res, carry} = {1'b0, acc_out};
      default: res = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc_out <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_n  <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && op_valid) begin
        if (op_code == 3'b111) begin
          mcand   <= acc_out[7:0];
          mplier  <= operand[7:0];
          product <= '0;
          cnt     <= '0;
          state   <= MUL;
        end else begin
          acc_out <= res;
          flag_z  <= (res == '0);
          flag_c  <= carry;
          flag_n  <= res[WIDTH-1];
          done    <= 1'b1;
        end
      end else if (state == MUL) begin
        product <= prod_next;
        cnt     <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          acc_out <= prod_next;
          flag_z  <= (prod_next == '0);
          flag_c  <= 1'b0;
          flag_n  <= prod_next[WIDTH-1];
          done    <= 1'b1;
          state   <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_accumulator_alu.sv
// tb_accumulator_alu: directed self-checking bench for accumulator_alu
module tb_accumulator_alu;
  localparam logic [2:0] LOAD = 3'b000, ADD = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                         XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MULT = 3'b111;
  logic        clk = 1'b0, rst = 1'b1, op_valid = 1'b0, op_ready, done, busy;
  logic        flag_z, flag_c, flag_n;
  logic [2:0]  op_code = '0;
  logic [15:0] operand = '0, acc_out;
  int checks = 0, errors = 0;

  accumulator_alu dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .operand(operand), .acc_out(acc_out),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [2:0] op, input logic [15:0] val);
    op_valid = 1'b1;
    op_code  = op;
    operand  = val;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(LOAD, 16'h1234);
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", op_ready); end
    @(negedge clk);
    checks++;
    if ({acc_out, flag_z, flag_c, flag_n, done, busy, op_ready} !== {16'h0000, 6'b000000}) begin
      errors++;
      $display("FAIL reset_state: acc=%h zcn=%b%b%b done=%b busy=%b ready=%b expected 0000 all zero",
               acc_out, flag_z, flag_c, flag_n, done, busy, op_ready);
    end
    rst = 1'b0;
    op_valid = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", op_ready); end
  endtask

  task automatic test_add_overflow;
    @(negedge clk);
    drive(LOAD, 16'h7FFF);
    @(negedge clk);
    checks++;
    if ({acc_out, done} !== {16'h7FFF, 1'b1}) begin
      errors++; $display("FAIL load_7fff: acc=%h done=%b expected 7fff 1", acc_out, done);
    end
    drive(ADD, 16'h0001);
    @(negedge clk);
    checks++;
    if ({acc_out, flag_z, flag_c, flag_n, done} !== {16'h8000, 4'b0011}) begin
      errors++; $display("FAIL add_to_8000: acc=%h zcn=%b%b%b done=%b expected 8000 001 1",
                         acc_out, flag_z, flag_c, flag_n, done);
    end
    op_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({acc_out, done} !== {16'h8000, 1'b0}) begin
      errors++; $display("FAIL done_single_pulse: acc=%h done=%b expected 8000 0", acc_out, done);
    end
  endtask

  task automatic test_add_wrap;
    drive(LOAD, 16'h0001);
    @(negedge clk);
    drive(ADD, 16'hFFFF);
    @(negedge clk);
    checks++;
    if ({acc_out, flag_z, flag_c, flag_n, done} !== {16'h0000, 4'b1101}) begin
      errors++; $display("FAIL add_wrap: acc=%h zcn=%b%b%b done=%b expected 0000 110 1",
                         acc_out, flag_z, flag_c, flag_n, done);
    end
    op_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_logic_shift;
    drive(LOAD, 16'h8001);
    @(negedge clk);
    drive(SHL, 16'h0000);
    @(negedge clk);
    checks++;
    if ({acc_out, flag_z, flag_c, flag_n} !== {16'h0002, 3'b010}) begin
      errors++; $display("FAIL shl: acc=%h zcn=%b%b%b expected 0002 010", acc_out, flag_z, flag_c, flag_n);
    end
    drive(LOAD, 16'h0003);
    @(negedge clk);
    drive(SHR, 16'h0000);
    @(negedge clk);
    checks++;
    if ({acc_out, flag_z, flag_c, flag_n} !== {16'h0001, 3'b010}) begin
      errors++; $display("FAIL shr: acc=%h zcn=%b%b%b expected 0001 010", acc_out, flag_z, flag_c, flag_n);
    end
    drive(LOAD, 16'hF0F0);
    @(negedge clk);
    drive(AND_, 16'h0F0F);
    @(negedge clk);
    checks++;
    if ({acc_out, flag_z, flag_c, flag_n} !== {16'h0000, 3'b100}) begin
      errors++; $display("FAIL and: acc=%h zcn=%b%b%b expected 0000 100", acc_out, flag_z, flag_c, flag_n);
    end
    drive(LOAD, 16'h00F0);
    @(negedge clk);
    drive(OR_, 16'hFF00);
    @(negedge clk);
    checks++;
    if ({acc_out, flag_z, flag_c, flag_n} !== {16'hFFF0, 3'b001}) begin
      errors++; $display("FAIL or: acc=%h zcn=%b%b%b expected fff0 001", acc_out, flag_z, flag_c, flag_n);
    end
    drive(XOR_, 16'h0FF0);
    @(negedge clk);
    checks++;
    if ({acc_out, flag_z, flag_c, flag_n} !== {16'hF000, 3'b001}) begin
      errors++; $display("FAIL xor: acc=%h zcn=%b%b%b expected f000 001", acc_out, flag_z, flag_c, flag_n);
    end
    op_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_held_add;
    int busy_cycles;
    logic held_ok;
    drive(LOAD, 16'h00FF);
    @(negedge clk);
    drive(MULT, 16'h00FF);
    @(negedge clk);
    drive(ADD, 16'h0001);
    busy_cycles = 0;
    held_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (busy && !op_ready && !done) busy_cycles++;
      if (acc_out !== 16'h00FF) held_ok = 1'b0;
    end
    checks++;
    if (busy_cycles != 8) begin errors++; $display("FAIL mul_busy_window: got %0d cycles expected 8", busy_cycles); end
    checks++;
    if (held_ok !== 1'b1) begin errors++; $display("FAIL mul_acc_held: acc changed during busy, last %h expected 00ff", acc_out); end
    @(negedge clk);
    checks++;
    if ({acc_out, flag_z, flag_c, flag_n, done, busy, op_ready} !== {16'hFE01, 6'b001101}) begin
      errors++; $display("FAIL mul_result: acc=%h zcn=%b%b%b done=%b busy=%b ready=%b expected fe01 001 1 0 1",
                         acc_out, flag_z, flag_c, flag_n, done, busy, op_ready);
    end
    @(negedge clk);
    checks++;
    if ({acc_out, done} !== {16'hFE02, 1'b1}) begin
      errors++; $display("FAIL held_add_at_e9: acc=%h done=%b expected fe02 1", acc_out, done);
    end
    op_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul_reset;
    logic saw_done;
    int wait_cycles;
    drive(LOAD, 16'h0012);
    @(negedge clk);
    drive(MULT, 16'h0034);
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({acc_out, done, busy, op_ready} !== {16'h0000, 3'b000}) begin
      errors++; $display("FAIL mul_abort: acc=%h done=%b busy=%b ready=%b expected 0000 0 0 0",
                         acc_out, done, busy, op_ready);
    end
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++;
    if ({saw_done, op_ready, acc_out} !== {2'b01, 16'h0000}) begin
      errors++; $display("FAIL mul_abort_quiet: done_seen=%b ready=%b acc=%h expected 0 1 0000",
                         saw_done, op_ready, acc_out);
    end
    drive(LOAD, 16'h0012);
    @(negedge clk);
    drive(MULT, 16'h0034);
    @(negedge clk);
    op_valid = 1'b0;
    wait_cycles = 0;
    while (!done && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    checks++;
    if ({done, acc_out, flag_z, flag_c, flag_n} !== {1'b1, 16'h03A8, 3'b000}) begin
      errors++; $display("FAIL mul_repeat: done=%b acc=%h zcn=%b%b%b after %0d cycles expected 1 03a8 000",
                         done, acc_out, flag_z, flag_c, flag_n, wait_cycles);
    end
    checks++;
    if (wait_cycles != 8) begin errors++; $display("FAIL mul_latency: got %0d expected 8", wait_cycles); end
  endtask

  initial begin
    test_reset;
    test_add_overflow;
    test_add_wrap;
    test_logic_shift;
    test_mul_held_add;
    test_mul_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
